// File: rtl/mask_engine_mc_pkg.sv
// Shared encodings for the mask engine: entry status values, FSM states and
// the per-entry segment width derivation.
package tcam_pkg;

    localparam logic [1:0] ST_VALID = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_RESULT  = 2'd3
    } state_e;

    // Entry layout is status, ID, MASK, KEY, PRIO with PRIO as wide as ID.
    function automatic int seg_width(input int kwid, input int idwid, input int maskwid);
        return 2 + idwid + maskwid + kwid + idwid;
    endfunction

endpackage

// File: rtl/mask_engine_mc_if.sv
// Search-beat input and result handshake bundle of the mask engine.
interface mask_engine_mc_if
    import tcam_pkg::*;
#(
    parameter int KWID    = 10,
    parameter int IDWID   = 2,
    parameter int MASKWID = 5,
    parameter int NSLOT   = 2,
    parameter int CNTWID  = 4
) ();
    localparam int SEGWID = seg_width(KWID, IDWID, MASKWID);

    logic [NSLOT*SEGWID-1:0] i_sdram_readdata;
    logic [KWID-1:0]         i_search_key;
    logic                    i_cntl_s0_searchdatavalid;
    logic                    i_segment_complete;
    logic                    i_result_ready;
    logic [IDWID-1:0]        o_id;
    logic [MASKWID-1:0]      o_maskid;
    logic [KWID-1:0]         o_confirm_key;
    logic [IDWID-1:0]        o_priority;
    logic [CNTWID-1:0]       o_hit_count;
    logic                    o_result_valid;
    logic                    o_mask_complete;
    logic                    o_drop;

    modport slave (
        input  i_sdram_readdata, i_search_key, i_cntl_s0_searchdatavalid,
               i_segment_complete, i_result_ready,
        output o_id, o_maskid, o_confirm_key, o_priority, o_hit_count,
               o_result_valid, o_mask_complete, o_drop
    );

    modport master (
        output i_sdram_readdata, i_search_key, i_cntl_s0_searchdatavalid,
               i_segment_complete, i_result_ready,
        input  o_id, o_maskid, o_confirm_key, o_priority, o_hit_count,
               o_result_valid, o_mask_complete, o_drop
    );

endinterface

// File: rtl/mask_slot_select.sv
// Combinational qualify and minimum-priority pick across the slots of one beat;
// equal priorities resolve to the lowest slot index.
module mask_slot_select
    import tcam_pkg::*;
#(
    parameter int KWID       = 10,
    parameter int IDWID      = 2,
    parameter int MASKWID    = 5,
    parameter int NSLOT      = 2,
    parameter int CONFIRM_EN = 1,
    localparam int SEGWID    = seg_width(KWID, IDWID, MASKWID)
) (
    input  logic [NSLOT*SEGWID-1:0] i_beat,
    input  logic [KWID-1:0]         i_search_key,
    output logic                    o_hit,
    output logic [IDWID-1:0]        o_id,
    output logic [MASKWID-1:0]      o_mask,
    output logic [KWID-1:0]         o_key,
    output logic [IDWID-1:0]        o_prio,
    output logic [3:0]              o_count
);
    localparam int PRIOWID = IDWID;

    // Scan slots upward, replacing only on strictly smaller priority.
    always_comb begin
        logic [SEGWID-1:0] seg;
        logic              qual;
        o_hit   = 1'b0;
        o_id    = '0;
        o_mask  = '0;
        o_key   = '0;
        o_prio  = '0;
        o_count = 4'd0;
        seg     = '0;
        qual    = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
            seg  = i_beat[s*SEGWID +: SEGWID];
            qual = (seg[SEGWID-1 -: 2] == ST_VALID) &&
                   ((CONFIRM_EN == 0) || (seg[PRIOWID +: KWID] == i_search_key));
            if (qual) begin
                o_count = o_count + 4'd1;
                if (!o_hit || (seg[PRIOWID-1:0] < o_prio)) begin
                    o_hit  = 1'b1;
                    o_id   = seg[PRIOWID+KWID+MASKWID +: IDWID];
                    o_mask = seg[PRIOWID+KWID +: MASKWID];
                    o_key  = seg[PRIOWID +: KWID];
                    o_prio = seg[PRIOWID-1:0];
                end else begin
                    o_hit = 1'b1;
                end
            end else begin
                qual = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mask_engine_mc.sv
// Segment-level mask resolver: two-stage best-priority pipeline, saturating hit
// counter and a result handshake FSM.
module mask_engine_mc
    import tcam_pkg::*;
#(
    parameter int DATA_BITS  = 10,
    parameter int IDWID      = 2,
    parameter int MASKWID    = 5,
    parameter int NSLOT      = 2,
    parameter int CONFIRM_EN = 1,
    parameter int CNTWID     = 4
) (
    input logic             clk,
    input logic             reset,
    mask_engine_mc_if.slave bus
);
    localparam int KWID = DATA_BITS;
    localparam int CW   = CNTWID + 4;
    localparam logic [CW-1:0] CNT_MAX = CW'({CNTWID{1'b1}});

    state_e               state_q, state_d;
    logic                 drain_q, drain_d, seg_q, edge_s, beat_s, open_s;
    logic                 s1_valid_q, s1_valid_d, s1_hit_q, s1_hit_d;
    logic [IDWID-1:0]     s1_id_q, s1_id_d, s1_prio_q, s1_prio_d;
    logic [MASKWID-1:0]   s1_mask_q, s1_mask_d;
    logic [KWID-1:0]      s1_key_q, s1_key_d;
    logic [3:0]           s1_cnt_q, s1_cnt_d;
    logic                 best_valid_q, best_valid_d;
    logic [IDWID-1:0]     best_id_q, best_id_d, best_prio_q, best_prio_d;
    logic [MASKWID-1:0]   best_mask_q, best_mask_d;
    logic [KWID-1:0]      best_key_q, best_key_d;
    logic [CNTWID-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]        cnt_sum_s;
    logic [IDWID-1:0]     o_id_q, o_id_d, o_prio_q, o_prio_d;
    logic [MASKWID-1:0]   o_mask_q, o_mask_d;
    logic [KWID-1:0]      o_key_q, o_key_d;
    logic [CNTWID-1:0]    o_cnt_q, o_cnt_d;
    logic                 o_valid_q, o_valid_d, o_drop_q, o_drop_d;
    logic                 sel_hit_s;
    logic [IDWID-1:0]     sel_id_s, sel_prio_s;
    logic [MASKWID-1:0]   sel_mask_s;
    logic [KWID-1:0]      sel_key_s;
    logic [3:0]           sel_cnt_s;

    mask_slot_select #(
        .KWID(KWID), .IDWID(IDWID), .MASKWID(MASKWID), .NSLOT(NSLOT), .CONFIRM_EN(CONFIRM_EN)
    ) u_sel (
        .i_beat(bus.i_sdram_readdata), .i_search_key(bus.i_search_key),
        .o_hit(sel_hit_s), .o_id(sel_id_s), .o_mask(sel_mask_s), .o_key(sel_key_s),
        .o_prio(sel_prio_s), .o_count(sel_cnt_s)
    );

    assign edge_s = bus.i_segment_complete & ~seg_q;
    assign beat_s = bus.i_cntl_s0_searchdatavalid;
    assign open_s = (state_q == S_IDLE) || (state_q == S_COLLECT);

    // Pipeline stages, FSM next state and registered output values.
    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        s1_valid_d   = beat_s && open_s;
        s1_hit_d     = sel_hit_s;
        s1_id_d      = sel_id_s;
        s1_mask_d    = sel_mask_s;
        s1_key_d     = sel_key_s;
        s1_prio_d    = sel_prio_s;
        s1_cnt_d     = sel_cnt_s;
        best_valid_d = best_valid_q;
        best_id_d    = best_id_q;
        best_mask_d  = best_mask_q;
        best_key_d   = best_key_q;
        best_prio_d  = best_prio_q;
        cnt_d        = cnt_q;
        o_id_d       = o_id_q;
        o_mask_d     = o_mask_q;
        o_key_d      = o_key_q;
        o_prio_d     = o_prio_q;
        o_cnt_d      = o_cnt_q;
        o_valid_d    = o_valid_q;
        o_drop_d     = 1'b0;
        cnt_sum_s    = CW'(cnt_q) + CW'(s1_cnt_q);

        // Earlier beats keep ties: only a strictly smaller priority replaces.
        if (s1_valid_q) begin
            if (s1_hit_q && (!best_valid_q || (s1_prio_q < best_prio_q))) begin
                best_valid_d = 1'b1;
                best_id_d    = s1_id_q;
                best_mask_d  = s1_mask_q;
                best_key_d   = s1_key_q;
                best_prio_d  = s1_prio_q;
            end else begin
                best_valid_d = best_valid_q;
            end
            cnt_d = (cnt_sum_s > CNT_MAX) ? {CNTWID{1'b1}} : cnt_sum_s[CNTWID-1:0];
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (edge_s) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else if (beat_s) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = state_q;
                end
            end
            S_DRAIN: begin
                o_drop_d = edge_s || beat_s;
                if (drain_q) begin
                    state_d   = S_RESULT;
                    o_id_d    = best_id_q;
                    o_mask_d  = best_mask_q;
                    o_key_d   = best_key_q;
                    o_prio_d  = best_prio_q;
                    o_cnt_d   = cnt_q;
                    o_valid_d = 1'b1;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_RESULT: begin
                o_drop_d = edge_s || beat_s;
                if (bus.i_result_ready) begin
                    state_d      = S_IDLE;
                    best_valid_d = 1'b0;
                    best_id_d    = '0;
                    best_mask_d  = '0;
                    best_key_d   = '0;
                    best_prio_d  = '0;
                    cnt_d        = '0;
                    o_id_d       = '0;
                    o_mask_d     = '0;
                    o_key_d      = '0;
                    o_prio_d     = '0;
                    o_cnt_d      = '0;
                    o_valid_d    = 1'b0;
                end else begin
                    state_d = S_RESULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pipeline and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            drain_q      <= 1'b0;
            seg_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_id_q      <= '0;
            s1_mask_q    <= '0;
            s1_key_q     <= '0;
            s1_prio_q    <= '0;
            s1_cnt_q     <= 4'd0;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_mask_q  <= '0;
            best_key_q   <= '0;
            best_prio_q  <= '0;
            cnt_q        <= '0;
            o_id_q       <= '0;
            o_mask_q     <= '0;
            o_key_q      <= '0;
            o_prio_q     <= '0;
            o_cnt_q      <= '0;
            o_valid_q    <= 1'b0;
            o_drop_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_q      <= drain_d;
            seg_q        <= bus.i_segment_complete;
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_id_q      <= s1_id_d;
            s1_mask_q    <= s1_mask_d;
            s1_key_q     <= s1_key_d;
            s1_prio_q    <= s1_prio_d;
            s1_cnt_q     <= s1_cnt_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_mask_q  <= best_mask_d;
            best_key_q   <= best_key_d;
            best_prio_q  <= best_prio_d;
            cnt_q        <= cnt_d;
            o_id_q       <= o_id_d;
            o_mask_q     <= o_mask_d;
            o_key_q      <= o_key_d;
            o_prio_q     <= o_prio_d;
            o_cnt_q      <= o_cnt_d;
            o_valid_q    <= o_valid_d;
            o_drop_q     <= o_drop_d;
        end
    end

    assign bus.o_id            = o_id_q;
    assign bus.o_maskid        = o_mask_q;
    assign bus.o_confirm_key   = o_key_q;
    assign bus.o_priority      = o_prio_q;
    assign bus.o_hit_count     = o_cnt_q;
    assign bus.o_result_valid  = o_valid_q;
    assign bus.o_mask_complete = o_valid_q;
    assign bus.o_drop          = o_drop_q;

endmodule

// File: tb/tb_mask_engine_mc.sv
// Bench for mask_engine_mc: default instance plus a CNTWID=2 twin sharing stimulus.
module tb_mask_engine_mc;
    localparam int KW = 10;
    localparam int SW = 21;
    localparam logic [9:0] KEY = 10'h2A5;

    typedef struct {
        logic [1:0] id;
        logic [4:0] m;
        logic [9:0] k;
        logic [1:0] p;
        int         hits;
    } exp_t;

    typedef struct {
        logic [SW-1:0] s0;
        logic [SW-1:0] s1;
        bit            same;
        exp_t          e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2*SW-1:0] rd;
    logic [KW-1:0] skey;
    logic          dv, seg, rdy;
    int            checks = 0;
    int            failures = 0;
    exp_t          sb[$];

    mask_engine_mc_if #(.KWID(KW), .IDWID(2), .MASKWID(5), .NSLOT(2), .CNTWID(4)) bus_a ();
    mask_engine_mc_if #(.KWID(KW), .IDWID(2), .MASKWID(5), .NSLOT(2), .CNTWID(2)) bus_b ();

    assign bus_a.i_sdram_readdata = rd;
    assign bus_a.i_search_key = skey;
    assign bus_a.i_cntl_s0_searchdatavalid = dv;
    assign bus_a.i_segment_complete = seg;
    assign bus_a.i_result_ready = rdy;
    assign bus_b.i_sdram_readdata = rd;
    assign bus_b.i_search_key = skey;
    assign bus_b.i_cntl_s0_searchdatavalid = dv;
    assign bus_b.i_segment_complete = seg;
    assign bus_b.i_result_ready = rdy;

    mask_engine_mc #(.DATA_BITS(KW), .IDWID(2), .MASKWID(5), .NSLOT(2), .CONFIRM_EN(1), .CNTWID(4))
        dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    mask_engine_mc #(.DATA_BITS(KW), .IDWID(2), .MASKWID(5), .NSLOT(2), .CONFIRM_EN(1), .CNTWID(2))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] ent(input logic [1:0] st, input logic [1:0] id,
                                          input logic [4:0] m, input logic [9:0] k,
                                          input logic [1:0] p);
        return {st, id, m, k, p};
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_outputs(input exp_t e, input string tag);
        chk({tag, "_id"},    32'(bus_a.o_id), 32'(e.id));
        chk({tag, "_mask"},  32'(bus_a.o_maskid), 32'(e.m));
        chk({tag, "_key"},   32'(bus_a.o_confirm_key), 32'(e.k));
        chk({tag, "_prio"},  32'(bus_a.o_priority), 32'(e.p));
        chk({tag, "_hits"},  32'(bus_a.o_hit_count), 32'(sat(e.hits, 4)));
        chk({tag, "_valid"}, 32'(bus_a.o_result_valid), 32'd1);
        chk({tag, "_mc"},    32'(bus_a.o_mask_complete), 32'd1);
        chk({tag, "_id_b"},  32'(bus_b.o_id), 32'(e.id));
        chk({tag, "_hits_b"}, 32'(bus_b.o_hit_count), 32'(sat(e.hits, 2)));
        chk({tag, "_valid_b"}, 32'(bus_b.o_result_valid), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus_a.o_result_valid), 32'd0);
        chk({tag, "_mc"},    32'(bus_a.o_mask_complete), 32'd0);
        chk({tag, "_fields"}, 32'({bus_a.o_id, bus_a.o_maskid, bus_a.o_confirm_key, bus_a.o_priority}), 32'd0);
        chk({tag, "_hits"},  32'(bus_a.o_hit_count), 32'd0);
        chk({tag, "_drop"},  32'(bus_a.o_drop), 32'd0);
        chk({tag, "_valid_b"}, 32'(bus_b.o_result_valid), 32'd0);
        chk({tag, "_hits_b"}, 32'(bus_b.o_hit_count), 32'd0);
    endtask

    // Wait (bounded) for the result, check latency and pop the scoreboard.
    task automatic wait_result(input int lat, input string tag, output exp_t e);
        int n;
        n = 0;
        while (bus_a.o_result_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        e = '{id: 2'd0, m: 5'd0, k: 10'd0, p: 2'd0, hits: 0};
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk_outputs(e, tag);
        end
    endtask

    task automatic accept(input string tag);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk({tag, "_acc_valid"}, 32'(bus_a.o_result_valid), 32'd0);
        chk({tag, "_acc_valid_b"}, 32'(bus_b.o_result_valid), 32'd0);
        chk({tag, "_acc_hits"}, 32'(bus_a.o_hit_count), 32'd0);
    endtask

    task automatic send_edge();
        seg = 1'b1;
        tick();
        seg = 1'b0;
    endtask

    initial begin
        vec_t vt[6];
        exp_t e;
        int   drops_a, drops_b;
        rd = '0; skey = KEY; dv = 1'b0; seg = 1'b0; rdy = 1'b0;

        vt[0] = '{ent(2'b01, 2'd1, 5'h03, KEY, 2'd3), ent(2'b01, 2'd2, 5'h11, KEY, 2'd1), 1'b0,
                  '{2'd2, 5'h11, KEY, 2'd1, 2}};
        vt[1] = '{ent(2'b01, 2'd3, 5'h07, KEY, 2'd2), ent(2'b01, 2'd1, 5'h09, KEY, 2'd2), 1'b1,
                  '{2'd3, 5'h07, KEY, 2'd2, 2}};
        vt[2] = '{ent(2'b01, 2'd1, 5'h05, 10'h2A4, 2'd0), ent(2'b01, 2'd2, 5'h06, 10'h000, 2'd1), 1'b0,
                  '{2'd0, 5'h00, 10'h000, 2'd0, 0}};
        vt[3] = '{ent(2'b10, 2'd1, 5'h0C, KEY, 2'd0), ent(2'b01, 2'd2, 5'h1F, KEY, 2'd3), 1'b0,
                  '{2'd2, 5'h1F, KEY, 2'd3, 1}};
        vt[4] = '{ent(2'b00, 2'd1, 5'h01, KEY, 2'd0), ent(2'b11, 2'd2, 5'h02, KEY, 2'd0), 1'b1,
                  '{2'd0, 5'h00, 10'h000, 2'd0, 0}};
        vt[5] = '{ent(2'b01, 2'd0, 5'h15, KEY, 2'd0), ent(2'b11, 2'd3, 5'h01, KEY, 2'd0), 1'b0,
                  '{2'd0, 5'h15, KEY, 2'd0, 1}};

        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();
        check_zero("idle");

        for (int i = 0; i < 6; i++) begin
            rd = {vt[i].s1, vt[i].s0};
            dv = 1'b1;
            sb.push_back(vt[i].e);
            if (vt[i].same) begin
                seg = 1'b1;
                tick();
                dv = 1'b0;
                seg = 1'b0;
            end else begin
                tick();
                dv = 1'b0;
                send_edge();
            end
            wait_result(2, $sformatf("vec%0d", i), e);
            accept($sformatf("vec%0d", i));
        end

        // Equal priority across beats: the earlier beat is kept.
        dv = 1'b1;
        rd = {ent(2'b00, 2'd2, 5'h03, KEY, 2'd0), ent(2'b01, 2'd1, 5'h02, KEY, 2'd2)};
        tick();
        rd = {ent(2'b01, 2'd3, 5'h04, KEY, 2'd2), ent(2'b00, 2'd0, 5'h00, KEY, 2'd0)};
        tick();
        dv = 1'b0;
        sb.push_back('{2'd1, 5'h02, KEY, 2'd2, 2});
        send_edge();
        wait_result(2, "tie_beats", e);
        accept("tie_beats");

        // Edge with no beats still yields an empty result.
        sb.push_back('{2'd0, 5'h00, 10'h000, 2'd0, 0});
        send_edge();
        wait_result(2, "empty_edge", e);
        accept("empty_edge");

        // Six hits over three beats; the twin saturates its counter at 3.
        dv = 1'b1;
        rd = {ent(2'b01, 2'd2, 5'h02, KEY, 2'd3), ent(2'b01, 2'd1, 5'h01, KEY, 2'd3)};
        tick();
        rd = {ent(2'b01, 2'd0, 5'h04, KEY, 2'd1), ent(2'b01, 2'd3, 5'h03, KEY, 2'd2)};
        tick();
        rd = {ent(2'b01, 2'd1, 5'h06, KEY, 2'd0), ent(2'b01, 2'd2, 5'h05, KEY, 2'd1)};
        tick();
        dv = 1'b0;
        sb.push_back('{2'd1, 5'h06, KEY, 2'd0, 6});
        send_edge();
        wait_result(2, "sat", e);
        accept("sat");

        // Hold in RESULT with a stray beat and edge; each must pulse o_drop.
        dv = 1'b1;
        rd = {ent(2'b00, 2'd0, 5'h00, KEY, 2'd0), ent(2'b01, 2'd2, 5'h0A, KEY, 2'd1)};
        tick();
        dv = 1'b0;
        sb.push_back('{2'd2, 5'h0A, KEY, 2'd1, 1});
        send_edge();
        wait_result(2, "hold", e);
        drops_a = 0;
        drops_b = 0;
        for (int c = 0; c < 5; c++) begin
            dv = (c == 0);
            seg = (c == 2);
            if (c == 0) rd = {ent(2'b01, 2'd3, 5'h1E, KEY, 2'd0), ent(2'b01, 2'd3, 5'h1E, KEY, 2'd0)};
            tick();
            drops_a += int'(bus_a.o_drop);
            drops_b += int'(bus_b.o_drop);
        end
        dv = 1'b0;
        seg = 1'b0;
        chk("hold_drops", 32'(drops_a), 32'd2);
        chk("hold_drops_b", 32'(drops_b), 32'd2);
        chk_outputs(e, "hold_after");
        accept("hold");

        // A beat in the first drain cycle is discarded.
        dv = 1'b1;
        rd = {ent(2'b00, 2'd0, 5'h00, KEY, 2'd0), ent(2'b01, 2'd1, 5'h03, KEY, 2'd2)};
        seg = 1'b1;
        tick();
        seg = 1'b0;
        rd = {ent(2'b01, 2'd3, 5'h1C, KEY, 2'd0), ent(2'b01, 2'd3, 5'h1C, KEY, 2'd0)};
        tick();
        dv = 1'b0;
        chk("drain_drop", 32'(bus_a.o_drop), 32'd1);
        sb.push_back('{2'd1, 5'h03, KEY, 2'd2, 1});
        wait_result(1, "drain_beat", e);
        accept("drain_beat");

        // Reset while draining abandons the segment silently.
        dv = 1'b1;
        rd = {vt[0].s1, vt[0].s0};
        seg = 1'b1;
        tick();
        dv = 1'b0;
        seg = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("rst_drain");
        for (int c = 0; c < 4; c++) tick();
        check_zero("rst_quiet");
        rd = {vt[0].s1, vt[0].s0};
        dv = 1'b1;
        tick();
        dv = 1'b0;
        sb.push_back(vt[0].e);
        send_edge();
        wait_result(2, "post_rst", e);
        accept("post_rst");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mask_engine_mc.md
MASK_ENGINE_MC -- requirements
Module: mask_engine_mc

Interface
REQ-001 Parameter DATA_BITS, 10, key width KWID.
REQ-002 Parameter IDWID, 2, ID width; PRIOWID equals IDWID.
REQ-003 Parameter MASKWID, 5, mask-ID width.
REQ-004 Parameter NSLOT, 2, entries per SDRAM read beat; legal range is 1 to 8.
REQ-005 Parameter CONFIRM_EN, 1, 1 = entry key must equal i_search_key; 0 = status check only.
REQ-006 Parameter CNTWID, 4, hit-counter width.
REQ-007 Derived SEGWID = 2+IDWID+MASKWID+KWID+PRIOWID; entry layout MSB to LSB is status[1:0], ID, MASK, KEY, PRIO; slot s occupies bits [(s+1)*SEGWID-1 : s*SEGWID].
REQ-008 clk  input  1  single clock; all state changes on rising edge.
REQ-009 reset  input  1  synchronous, active-high.
REQ-010 i_sdram_readdata  input  NSLOT*SEGWID  one beat of NSLOT entries.
REQ-011 i_search_key  input  KWID  key to confirm; stable for the whole segment.
REQ-012 i_cntl_s0_searchdatavalid  input  1  beat valid, one beat per high cycle.
REQ-013 i_segment_complete  input  1  level; its rising edge ends the segment.
REQ-014 i_result_ready  input  1  downstream accepts the result.
REQ-015 o_id / o_maskid / o_confirm_key / o_priority  output  IDWID / MASKWID / KWID / PRIOWID  winning entry fields.
REQ-016 o_hit_count  output  CNTWID  qualifying entries in the segment, saturating.
REQ-017 o_result_valid  output  1  result held for handshake.
REQ-018 o_mask_complete  output  1  segment resolved; equals o_result_valid.
REQ-019 o_drop  output  1  one-cycle pulse on an ignored beat or edge.

Function
REQ-020 FSM states: IDLE, COLLECT, DRAIN, RESULT.
- IDLE to COLLECT on the first valid beat.
- IDLE or COLLECT to DRAIN on the i_segment_complete rising edge, detected with a one-flop delayed copy.
REQ-021 An entry qualifies when status == 2'b01 and, if CONFIRM_EN = 1, its KEY equals i_search_key.
REQ-022 Stage 1 registers the beat winner: the qualifying slot with the numerically smallest PRIO; ties go to the lowest slot index. It also registers the beat's qualifying-entry count.
REQ-023 Stage 2 replaces the running best only on strictly smaller PRIO, so the earlier beat wins ties. o_hit_count adds the beat count and saturates at 2^CNTWID-1.
REQ-024 A beat valid in the same cycle as the segment edge is included in the result.
REQ-025 DRAIN lasts exactly 2 cycles, then RESULT. The edge is at cycle t; o_result_valid rises at t+3.
REQ-026 In RESULT, all outputs are held stable until i_result_ready = 1.
- On the accept cycle, the running best and hit count are cleared.
- The FSM goes to IDLE the next cycle; o_result_valid and o_mask_complete fall then.
REQ-027 A segment with no hit still produces a result: o_hit_count = 0 and all field outputs = 0.
REQ-028 A valid beat in DRAIN (other than the edge cycle) or in RESULT is discarded and o_drop pulses for 1 cycle.
REQ-029 A segment edge in DRAIN or RESULT is ignored and o_drop pulses for 1 cycle.
REQ-030 A segment edge in IDLE with no beats produces an empty result per REQ-027.

Reset
REQ-031 Reset puts the FSM in IDLE, clears the pipeline, best entry and edge flop, and drives every output to 0 on the next clock edge.
REQ-032 Reset mid-segment or during RESULT discards the result; no o_drop is asserted.

Structure
REQ-033 A shared package tcam_pkg SHALL hold the status encodings (2'b01 valid), FSM state enum and SEGWID derivation function.
REQ-034 One sub-module, mask_slot_select, SHALL hold the combinational NSLOT-way qualify and minimum-priority select with lowest-index tie-break.

Verification (defaults, NSLOT = 2)
REQ-035 One beat: slot0 = {01, ID 1, PRIO 3, key = search key}, slot1 = {01, ID 2, PRIO 1, key = search key}; then segment edge -> at t+3, o_id = 2, o_priority = 1, o_hit_count = 2.
REQ-036 Beat 1 has PRIO 2 (ID 1); beat 2 has PRIO 2 (ID 3) -> o_id = 1 (earlier beat wins the tie).
REQ-037 CONFIRM_EN = 1, all entries status 01 with key != search key -> o_hit_count = 0, o_id = 0, o_result_valid = 1.
REQ-038 Hold i_result_ready = 0 for 5 cycles in RESULT, send a beat and a segment edge -> outputs unchanged and o_drop pulses twice; ready = 1 -> IDLE next cycle.
REQ-039 CNTWID = 2 with 6 hits -> o_hit_count = 3.
REQ-040 Assert reset in DRAIN -> all outputs 0 next cycle; a new segment then resolves normally.
